writemem_arb: RTL

Round-robin arbiter and sequencer for the dual-port `writemem` result memory. It collects single-word write requests from up to `NREQ` producers (layer output stages, weight-update units) and packs up to two granted requests per cycle onto the memory's `addr1/data1` and `addr2/data2` slots. It also supports a flush handshake, so the top-level FSM can quiesce all writes before reading or dumping memory.

---
 rtl/writemem_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/writemem_arb.sv
// Round-robin arbiter packing up to two single-word writes per cycle onto the
// dual-port writemem slots, with a flush/drain handshake. Optional write-cycle
// counter is built only when WRITEMEM_ARB_COUNT_EN is defined.
module writemem_arb #(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   enable,
    output logic [DWIDTH-1:0]      addr1,
    output logic [DWIDTH-1:0]      data1,
    output logic [DWIDTH-1:0]      addr2,
    output logic [DWIDTH-1:0]      data2,
    output logic [31:0]            wr_count
);
    localparam int PW = $clog2(NREQ);
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    ptr_t   ptr_q, ptr_d;
    logic   enable_q, enable_d;
    logic [DWIDTH-1:0] addr1_q, addr1_d, data1_q, data1_d;
    logic [DWIDTH-1:0] addr2_q, addr2_d, data2_q, data2_d;

    logic [NREQ-1:0][DWIDTH-1:0] addr_v, data_v;
    assign addr_v = req_addr;
    assign data_v = req_data;

    function automatic ptr_t wrap_inc(ptr_t p, int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return ptr_t'(s);
    endfunction

    logic win1, win2, arb_en;
    ptr_t sel1, sel2;

    // Slot 1: first request from ptr; slot 2: next request cyclically after slot 1.
    always_comb begin
        win1 = 1'b0;
        win2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win1 && req[wrap_inc(ptr_q, k)]) begin
                win1 = 1'b1;
                sel1 = wrap_inc(ptr_q, k);
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            if (win1 && !win2 && req[wrap_inc(sel1, k)]) begin
                win2 = 1'b1;
                sel2 = wrap_inc(sel1, k);
            end
        end
    end

    assign arb_en = (state_q == RUN) && !flush && !rst;

    always_comb begin
        gnt = '0;
        if (arb_en && win1) gnt[sel1] = 1'b1;
        if (arb_en && win2) gnt[sel2] = 1'b1;
    end

    always_comb begin
        enable_d = 1'b0;
        ptr_d    = ptr_q;
        addr1_d  = addr1_q;
        data1_d  = data1_q;
        addr2_d  = addr2_q;
        data2_d  = data2_q;
        if (arb_en && win1) begin
            enable_d = 1'b1;
            addr1_d  = addr_v[sel1];
            data1_d  = data_v[sel1];
            if (win2) begin
                addr2_d = addr_v[sel2];
                data2_d = data_v[sel2];
                ptr_d   = wrap_inc(sel2, 1);
            end else begin
                // Lone winner is duplicated into slot 2; the repeat write is harmless.
                addr2_d = addr_v[sel1];
                data2_d = data_v[sel1];
                ptr_d   = wrap_inc(sel1, 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (!flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            ptr_q    <= '0;
            enable_q <= 1'b0;
            addr1_q  <= '0;
            data1_q  <= '0;
            addr2_q  <= '0;
            data2_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            enable_q <= enable_d;
            addr1_q  <= addr1_d;
            data1_q  <= data1_d;
            addr2_q  <= addr2_d;
            data2_q  <= data2_d;
        end
    end

    assign flush_done = (state_q == DONE) && flush;
    assign enable     = enable_q;
    assign addr1      = addr1_q;
    assign data1      = data1_q;
    assign addr2      = addr2_q;
    assign data2      = data2_q;

`ifdef WRITEMEM_ARB_COUNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (enable_d) cnt_q <= cnt_q + 32'd1;
    end
    assign wr_count = cnt_q;
`else
    assign wr_count = '0;
`endif
endmodule
